// File: rtl/counter_updown_param_negedge_sync_resetp.sv
// Parametrised up/down counter on negedge clock0: prescaled steps, wrap or saturate, load, terminal pulse.
// Optional COUNTER_OVF_STICKY_EN adds clear_ovf / overflow_sticky.
module counter_updown_param_negedge_sync_resetp #(
  parameter int WIDTH       = 16,
  parameter int MODULUS     = 0,
  parameter int SATURATE    = 0,
  parameter int RESET_VALUE = 0,
  parameter int PRESCALE    = 1
) (
  input  logic             clock0,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
`ifdef COUNTER_OVF_STICKY_EN
  input  logic             clear_ovf,
  output logic             overflow_sticky,
`endif
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX = (MODULUS == 0) ? {WIDTH{1'b1}} : WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] r_count;
  logic [PW-1:0]    r_pre;
  logic             r_term;

  logic             w_at_bnd;
  logic             w_step;
  logic             w_term;
  logic [WIDTH-1:0] w_count_nxt;
  logic [PW-1:0]    w_pre_nxt;

  always_comb begin
    w_at_bnd    = up_down ? (r_count == MAX) : (r_count == '0);
    w_step      = enable && !load && (r_pre == PRE_LAST);
    w_term      = w_step && w_at_bnd;
    w_count_nxt = r_count;
    w_pre_nxt   = r_pre;
    if (load) begin
      w_count_nxt = (load_value > MAX) ? MAX : load_value;
      w_pre_nxt   = '0;
    end else if (enable) begin
      w_pre_nxt = w_step ? '0 : PW'(r_pre + 1'b1);
      if (w_step) begin
        // Boundary step either wraps to the opposite end or holds.
        if (w_at_bnd) begin
          if (SATURATE == 0) w_count_nxt = up_down ? '0 : MAX;
        end else begin
          w_count_nxt = up_down ? WIDTH'(r_count + 1'b1) : WIDTH'(r_count - 1'b1);
        end
      end
    end
  end

  always_ff @(negedge clock0) begin
    if (reset) begin
      r_count <= WIDTH'(RESET_VALUE);
      r_pre   <= '0;
      r_term  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_pre   <= w_pre_nxt;
      r_term  <= w_term;
    end
  end

`ifdef COUNTER_OVF_STICKY_EN
  logic r_sticky;

  // Set has priority over a simultaneous clear.
  always_ff @(negedge clock0) begin
    if (reset)          r_sticky <= 1'b0;
    else if (w_term)    r_sticky <= 1'b1;
    else if (clear_ovf) r_sticky <= 1'b0;
  end

  assign overflow_sticky = r_sticky;
`endif

  assign count    = r_count;
  assign terminal = r_term;

endmodule

// File: tb/tb_counter_updown_param_negedge_sync_resetp.sv
// Directed bench for counter_updown_param_negedge_sync_resetp over four parameter sets.
module tb_counter_updown_param_negedge_sync_resetp;

  logic clock0 = 1'b0;
  always #5 clock0 = ~clock0;

  logic rst [4];
  logic en  [4];
  logic ud  [4];
  logic ld  [4];
  logic clr [4];
  logic stk [4];
  logic trm [4];

  logic [15:0] lv0, cnt0;
  logic [3:0]  lv1, cnt1;
  logic [3:0]  lv2, cnt2;
  logic [7:0]  lv3, cnt3;

  int n_cmp = 0;
  int n_err = 0;

  // A: full 16-bit, modulus 1000, reset value 5
  counter_updown_param_negedge_sync_resetp #(.WIDTH(16), .MODULUS(1000), .SATURATE(0), .RESET_VALUE(5), .PRESCALE(1)) u_a (
    .clock0(clock0), .reset(rst[0]), .enable(en[0]), .up_down(ud[0]), .load(ld[0]), .load_value(lv0),
`ifdef COUNTER_OVF_STICKY_EN
    .clear_ovf(clr[0]), .overflow_sticky(stk[0]),
`endif
    .count(cnt0), .terminal(trm[0]));

  // B: mod 10 wrapping
  counter_updown_param_negedge_sync_resetp #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VALUE(0), .PRESCALE(1)) u_b (
    .clock0(clock0), .reset(rst[1]), .enable(en[1]), .up_down(ud[1]), .load(ld[1]), .load_value(lv1),
`ifdef COUNTER_OVF_STICKY_EN
    .clear_ovf(clr[1]), .overflow_sticky(stk[1]),
`endif
    .count(cnt1), .terminal(trm[1]));

  // C: mod 10 saturating
  counter_updown_param_negedge_sync_resetp #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .RESET_VALUE(0), .PRESCALE(1)) u_c (
    .clock0(clock0), .reset(rst[2]), .enable(en[2]), .up_down(ud[2]), .load(ld[2]), .load_value(lv2),
`ifdef COUNTER_OVF_STICKY_EN
    .clear_ovf(clr[2]), .overflow_sticky(stk[2]),
`endif
    .count(cnt2), .terminal(trm[2]));

  // D: prescale 3, full 8-bit range
  counter_updown_param_negedge_sync_resetp #(.WIDTH(8), .MODULUS(0), .SATURATE(0), .RESET_VALUE(0), .PRESCALE(3)) u_d (
    .clock0(clock0), .reset(rst[3]), .enable(en[3]), .up_down(ud[3]), .load(ld[3]), .load_value(lv3),
`ifdef COUNTER_OVF_STICKY_EN
    .clear_ovf(clr[3]), .overflow_sticky(stk[3]),
`endif
    .count(cnt3), .terminal(trm[3]));

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock0);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; en[i] = 1'b0; ud[i] = 1'b1; ld[i] = 1'b0; clr[i] = 1'b0;
      stk[i] = 1'b0;
    end
    lv0 = '0; lv1 = '0; lv2 = '0; lv3 = '0;
    en[0] = 1'b1;

    // Reset held three edges with enable asserted
    tick(1); chk("a_rst1_cnt", cnt0, 5); chk("a_rst1_term", trm[0], 0);
    tick(1); chk("a_rst2_cnt", cnt0, 5);
    tick(1); chk("a_rst3_cnt", cnt0, 5);
    chk("d_rst_cnt", cnt3, 0);
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    tick(1); chk("a_up6", cnt0, 6); chk("a_up6_term", trm[0], 0);
    tick(1); chk("a_up7", cnt0, 7); chk("a_up7_term", trm[0], 0);

    // Load clamps to MAX and beats enable
    ld[0] = 1'b1; lv0 = 16'hFFFF;
    tick(1); chk("a_load_clamp", cnt0, 999); chk("a_load_term", trm[0], 0);
    ld[0] = 1'b0;
    tick(1); chk("a_wrap_cnt", cnt0, 0); chk("a_wrap_term", trm[0], 1);
    ld[0] = 1'b1; rst[0] = 1'b1;
    tick(1); chk("a_rst_over_load", cnt0, 5);
    ld[0] = 1'b0; rst[0] = 1'b0; en[0] = 1'b0;
    tick(1); chk("a_hold", cnt0, 5);

    // B: wrap up 8 -> 9 -> 0 -> 1
    ld[1] = 1'b1; lv1 = 4'd8;
    tick(1); chk("b_load8", cnt1, 8);
    ld[1] = 1'b0; en[1] = 1'b1; ud[1] = 1'b1;
    tick(1); chk("b_up9", cnt1, 9); chk("b_up9_term", trm[1], 0);
    tick(1); chk("b_wrap0", cnt1, 0); chk("b_wrap0_term", trm[1], 1);
    tick(1); chk("b_up1", cnt1, 1); chk("b_up1_term", trm[1], 0);
    en[1] = 1'b0;
    tick(1); chk("b_hold", cnt1, 1);
    ld[1] = 1'b1; lv1 = 4'd0;
    tick(1); chk("b_load0", cnt1, 0);
    ld[1] = 1'b0; en[1] = 1'b1; ud[1] = 1'b0;
    tick(1); chk("b_down_wrap", cnt1, 9); chk("b_down_wrap_term", trm[1], 1);
    en[1] = 1'b0;
`ifdef COUNTER_OVF_STICKY_EN
    chk("b_stk_set", stk[1], 1);
    tick(10); chk("b_stk_held", stk[1], 1); chk("b_stk_term_low", trm[1], 0);
    en[1] = 1'b1; ud[1] = 1'b1; clr[1] = 1'b1;
    tick(1); chk("b_stk_set_wins", stk[1], 1); chk("b_stk_wrap_cnt", cnt1, 0);
    en[1] = 1'b0;
    tick(1); chk("b_stk_cleared", stk[1], 0);
    clr[1] = 1'b0;
`endif

    // C: saturating down then up
    ld[2] = 1'b1; lv2 = 4'd1;
    tick(1); chk("c_load1", cnt2, 1);
    ld[2] = 1'b0; en[2] = 1'b1; ud[2] = 1'b0;
    tick(1); chk("c_dn0", cnt2, 0); chk("c_dn0_term", trm[2], 0);
    tick(1); chk("c_sat0a", cnt2, 0); chk("c_sat0a_term", trm[2], 1);
    tick(1); chk("c_sat0b", cnt2, 0); chk("c_sat0b_term", trm[2], 1);
    ud[2] = 1'b1;
    tick(1); chk("c_up1", cnt2, 1); chk("c_up1_term", trm[2], 0);
    ld[2] = 1'b1; lv2 = 4'd12;
    tick(1); chk("c_load_clamp", cnt2, 9);
    ld[2] = 1'b0;
    tick(1); chk("c_sat9", cnt2, 9); chk("c_sat9_term", trm[2], 1);
    en[2] = 1'b0;

    // D: prescale by 3 with an enable gap
    en[3] = 1'b1; ud[3] = 1'b1;
    tick(2); chk("d_e2", cnt3, 0);
    tick(1); chk("d_e3", cnt3, 1);
    tick(1); chk("d_e4", cnt3, 1);
    en[3] = 1'b0;
    tick(5); chk("d_gap", cnt3, 1);
    en[3] = 1'b1;
    tick(1); chk("d_resume1", cnt3, 1);
    tick(1); chk("d_resume2", cnt3, 2); chk("d_resume2_term", trm[3], 0);
    // Partial prescale period discarded by reset
    tick(1);
    rst[3] = 1'b1;
    tick(1); chk("d_rst", cnt3, 0);
    rst[3] = 1'b0;
    tick(2); chk("d_rst_e2", cnt3, 0);
    tick(1); chk("d_rst_e3", cnt3, 1);
    // Load clears prescaler
    tick(1);
    ld[3] = 1'b1; lv3 = 8'd255;
    tick(1); chk("d_load", cnt3, 255);
    ld[3] = 1'b0;
    tick(2); chk("d_load_e2", cnt3, 255);
    tick(1); chk("d_wrap", cnt3, 0); chk("d_wrap_term", trm[3], 1);
    ud[3] = 1'b0;
    tick(3); chk("d_down_wrap", cnt3, 255); chk("d_down_term", trm[3], 1);
    en[3] = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
